elevator_ctrl: RTL and testbench



---
 rtl/elevator_pkg.sv | 40 ++++
 rtl/elevator_ctrl_dirsel.sv | 27 ++
 rtl/elevator_ctrl.sv | 144 ++++++++++++++
 tb/tb_elevator_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared constants, state encoding and floor-mask helpers for the elevator car scheduler.
package elevator_pkg;

  localparam int unsigned NFLOORS        = 5;
  localparam int unsigned FW             = $clog2(NFLOORS);
  localparam int unsigned TRAVEL_CYC_DEF = 8;
  localparam int unsigned DOOR_CYC_DEF   = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_t;

  // Timer must hold max(travel, door) - 1; never narrower than one bit.
  function automatic int unsigned tmr_w(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic logic [NFLOORS-1:0] onehot(input logic [FW-1:0] f);
    logic [NFLOORS-1:0] m;
    for (int unsigned i = 0; i < NFLOORS; i++) m[i] = (FW'(i) == f);
    return m;
  endfunction

  function automatic logic [NFLOORS-1:0] above_mask(input logic [FW-1:0] f);
    logic [NFLOORS-1:0] m;
    for (int unsigned i = 0; i < NFLOORS; i++) m[i] = (FW'(i) > f);
    return m;
  endfunction

  function automatic logic [NFLOORS-1:0] below_mask(input logic [FW-1:0] f);
    logic [NFLOORS-1:0] m;
    for (int unsigned i = 0; i < NFLOORS; i++) m[i] = (FW'(i) < f);
    return m;
  endfunction

endpackage

// File: rtl/elevator_ctrl_dirsel.sv
// Combinational request classification and SCAN direction choice at the current floor.
module elevator_ctrl_dirsel
  import elevator_pkg::*;
(
  input  logic [NFLOORS-1:0] i_req,
  input  logic [FW-1:0]      i_floor,
  input  logic               i_dir_up,
  output logic               o_above_c,
  output logic               o_below_c,
  output logic               o_here_c,
  output logic               o_go_c,
  output logic               o_go_up_c
);

  logic w_above;
  logic w_below;

  assign w_above   = |(i_req & above_mask(i_floor));
  assign w_below   = |(i_req & below_mask(i_floor));
  assign o_above_c = w_above;
  assign o_below_c = w_below;
  assign o_here_c  = |(i_req & onehot(i_floor));
  assign o_go_c    = w_above | w_below;
  // Keep the current direction while work remains that way, otherwise reverse.
  assign o_go_up_c = i_dir_up ? w_above : ~w_below;

endmodule

// File: rtl/elevator_ctrl.sv
// SCAN car-motion scheduler: moves floor by floor, opens the door at served floors, pulses clr.
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int unsigned TRAVEL_CYC = TRAVEL_CYC_DEF,
  parameter int unsigned DOOR_CYC   = DOOR_CYC_DEF
) (
  input  logic               ck,
  input  logic               rst_n,
  input  logic [NFLOORS-1:0] req,
  input  logic               hold,
  output logic [NFLOORS-1:0] clr,
  output logic [FW-1:0]      floor,
  output logic               mot_up,
  output logic               mot_dn,
  output logic               door_open,
  output logic               dir_up,
  output logic               busy
);

  localparam int unsigned    TW          = tmr_w(TRAVEL_CYC, DOOR_CYC);
  localparam logic [TW-1:0]  TRAVEL_LOAD = TW'(TRAVEL_CYC - 1);
  localparam logic [TW-1:0]  DOOR_LOAD   = TW'(DOOR_CYC - 1);

  state_t              r_state;
  logic [TW-1:0]       r_timer;
  logic [FW-1:0]       r_floor;
  logic                r_dir_up;
  logic [NFLOORS-1:0]  r_clr;
  logic                r_mot_up;
  logic                r_mot_dn;
  logic                r_door;
  logic                r_busy;

  logic                w_above;
  logic                w_below;
  logic                w_here;
  logic                w_go;
  logic                w_go_up;
  logic [FW-1:0]       w_nf;
  logic                w_here_n;
  logic                w_beyond;
  logic                w_clr_here;

  elevator_ctrl_dirsel u_dirsel (
    .i_req     (req),
    .i_floor   (r_floor),
    .i_dir_up  (r_dir_up),
    .o_above_c (w_above),
    .o_below_c (w_below),
    .o_here_c  (w_here),
    .o_go_c    (w_go),
    .o_go_up_c (w_go_up)
  );

  // Arrival evaluation at the floor the car is about to reach.
  assign w_nf       = r_dir_up ? (r_floor + FW'(1)) : (r_floor - FW'(1));
  assign w_here_n   = |(req & onehot(w_nf));
  assign w_beyond   = |(req & (r_dir_up ? above_mask(w_nf) : below_mask(w_nf)));
  // Latch may still show the request on the cycle its clear is being pulsed.
  assign w_clr_here = |(r_clr & onehot(r_floor));

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_timer  <= '0;
      r_floor  <= '0;
      r_dir_up <= 1'b1;
      r_clr    <= '0;
      r_mot_up <= 1'b0;
      r_mot_dn <= 1'b0;
      r_door   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_clr <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_here) begin
            r_state <= ST_DOOR;
            r_timer <= DOOR_LOAD;
            r_clr   <= onehot(r_floor);
            r_door  <= 1'b1;
            r_busy  <= 1'b1;
          end else if (w_go) begin
            r_state  <= ST_MOVE;
            r_timer  <= TRAVEL_LOAD;
            r_dir_up <= w_go_up;
            r_mot_up <= w_go_up;
            r_mot_dn <= ~w_go_up;
            r_busy   <= 1'b1;
          end
        end
        ST_MOVE: begin
          if (r_timer != '0) begin
            r_timer <= r_timer - TW'(1);
          end else begin
            r_floor <= w_nf;
            if (w_here_n) begin
              r_state  <= ST_DOOR;
              r_timer  <= DOOR_LOAD;
              r_clr    <= onehot(w_nf);
              r_door   <= 1'b1;
              r_mot_up <= 1'b0;
              r_mot_dn <= 1'b0;
            end else if (w_beyond) begin
              r_timer <= TRAVEL_LOAD;
            end else begin
              r_state  <= ST_IDLE;
              r_mot_up <= 1'b0;
              r_mot_dn <= 1'b0;
              r_busy   <= 1'b0;
            end
          end
        end
        ST_DOOR: begin
          if (w_here && !w_clr_here) begin
            r_clr   <= onehot(r_floor);
            r_timer <= DOOR_LOAD;
          end else if (hold) begin
            r_timer <= DOOR_LOAD;
          end else if (r_timer == '0) begin
            r_state <= ST_IDLE;
            r_door  <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign clr       = r_clr;
  assign floor     = r_floor;
  assign mot_up    = r_mot_up;
  assign mot_dn    = r_mot_dn;
  assign door_open = r_door;
  assign dir_up    = r_dir_up;
  assign busy      = r_busy;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl with an SR request-latch model fed back by clr.
module tb_elevator_ctrl;

  logic       ck;
  logic       rst_n;
  logic [4:0] req;
  logic       hold;
  logic [4:0] clr;
  logic [2:0] floor;
  logic       mot_up;
  logic       mot_dn;
  logic       door_open;
  logic       dir_up;
  logic       busy;

  logic [4:0] set_v;
  logic [4:0] r_pend;

  int n_chk;
  int n_err;
  int c_up;
  int c_dn;
  int c_door;
  int c_clr;
  int c_multi;

  elevator_ctrl dut (
    .ck        (ck),
    .rst_n     (rst_n),
    .req       (req),
    .hold      (hold),
    .clr       (clr),
    .floor     (floor),
    .mot_up    (mot_up),
    .mot_dn    (mot_dn),
    .door_open (door_open),
    .dir_up    (dir_up),
    .busy      (busy)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Request latch: set by the bench, reset (dominant) by the controller's clr.
  always @(posedge ck or negedge rst_n) begin
    if (!rst_n) r_pend <= '0;
    else        r_pend <= (r_pend | set_v) & ~clr;
  end
  assign req = (r_pend | set_v) & ~clr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    c_up   = 0;
    c_dn   = 0;
    c_door = 0;
    c_clr  = 0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge ck);
      if (mot_up)    c_up++;
      if (mot_dn)    c_dn++;
      if (door_open) c_door++;
      if (clr != 5'd0) c_clr++;
      if ((clr & (clr - 5'd1)) != 5'd0) c_multi++;
    end
  endtask

  task automatic req_pulse(input logic [4:0] v);
    clear_stats();
    set_v = v;
    run(1);
    set_v = '0;
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    c_multi = 0;
    clear_stats();
    set_v = '0;
    hold  = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge ck);

    chk("rst_floor",  32'(floor), 32'd0);
    chk("rst_dir_up", 32'(dir_up), 32'd1);
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_clr",    32'(clr), 32'd0);
    chk("rst_motors", 32'({mot_up, mot_dn}), 32'd0);
    chk("rst_door",   32'(door_open), 32'd0);
    rst_n = 1'b1;
    run(2);

    // Same floor: served without moving
    req_pulse(5'b00001);
    chk("same_door",  32'(door_open), 32'd1);
    chk("same_clr",   32'(clr), 32'b00001);
    run(6);
    chk("same_door_cycles", 32'(c_door), 32'd6);
    chk("same_clr_pulses",  32'(c_clr), 32'd1);
    chk("same_no_motor",    32'(c_up + c_dn), 32'd0);
    chk("same_idle",        32'(busy), 32'd0);

    // Up trip 0 -> 2
    req_pulse(5'b00100);
    chk("up_start_mot",   32'(mot_up), 32'd1);
    chk("up_start_floor", 32'(floor), 32'd0);
    run(7);
    chk("up_floor_n8",  32'(floor), 32'd0);
    run(1);
    chk("up_floor_n9",  32'(floor), 32'd1);
    run(7);
    chk("up_floor_n16", 32'(floor), 32'd1);
    run(1);
    chk("up_arrive_floor", 32'(floor), 32'd2);
    chk("up_arrive_door",  32'(door_open), 32'd1);
    chk("up_arrive_clr",   32'(clr), 32'b00100);
    chk("up_arrive_mot",   32'(mot_up), 32'd0);
    chk("up_mot_cycles",   32'(c_up), 32'd16);
    run(6);
    chk("up_door_cycles", 32'(c_door), 32'd6);
    chk("up_idle",        32'(busy), 32'd0);

    // Door hold at floor 2
    req_pulse(5'b00100);
    chk("hold_door_open", 32'(door_open), 32'd1);
    hold = 1'b1;
    clear_stats();
    run(20);
    hold = 1'b0;
    chk("hold_door_during", 32'(c_door), 32'd20);
    clear_stats();
    run(5);
    chk("hold_door_after5", 32'(c_door), 32'd5);
    run(1);
    chk("hold_door_closed", 32'(door_open), 32'd0);
    chk("hold_idle",        32'(busy), 32'd0);

    // Reasserted request during door: second clr, timer reload
    req_pulse(5'b00100);
    run(2);
    set_v = 5'b00100;
    run(1);
    set_v = '0;
    chk("reassert_clr", 32'(clr), 32'b00100);
    run(5);
    chk("reassert_door_n9",  32'(door_open), 32'd1);
    run(1);
    chk("reassert_door_n10", 32'(door_open), 32'd0);
    chk("reassert_clr_pulses", 32'(c_clr), 32'd2);
    chk("reassert_door_cycles", 32'(c_door), 32'd9);

    // Reset mid-move at floor 2
    req_pulse(5'b10000);
    run(3);
    chk("mid_move_mot",   32'(mot_up), 32'd1);
    chk("mid_move_floor", 32'(floor), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("abort_floor",  32'(floor), 32'd0);
    chk("abort_motors", 32'({mot_up, mot_dn}), 32'd0);
    chk("abort_door",   32'(door_open), 32'd0);
    chk("abort_clr",    32'(clr), 32'd0);
    chk("abort_busy",   32'(busy), 32'd0);
    @(negedge ck);
    rst_n = 1'b1;
    run(2);
    chk("abort_stays_idle", 32'(busy), 32'd0);

    // SCAN: going up past floor 1 with requests at 4 and 0
    req_pulse(5'b10000);
    run(8);
    chk("scan_floor1", 32'(floor), 32'd1);
    set_v = 5'b00001;
    run(1);
    set_v = '0;
    run(23);
    chk("scan_top_floor", 32'(floor), 32'd4);
    chk("scan_top_clr",   32'(clr), 32'b10000);
    chk("scan_top_door",  32'(door_open), 32'd1);
    chk("scan_up_cycles", 32'(c_up), 32'd32);
    run(6);
    chk("scan_idle_top", 32'(busy), 32'd0);
    chk("scan_dir_kept", 32'(dir_up), 32'd1);
    run(1);
    chk("scan_reverse_dir", 32'(dir_up), 32'd0);
    chk("scan_reverse_mot", 32'(mot_dn), 32'd1);
    run(32);
    chk("scan_bottom_floor", 32'(floor), 32'd0);
    chk("scan_bottom_clr",   32'(clr), 32'b00001);
    chk("scan_bottom_mot",   32'(mot_dn), 32'd0);
    chk("scan_dn_cycles",    32'(c_dn), 32'd32);
    run(6);
    chk("scan_clr_pulses", 32'(c_clr), 32'd2);
    chk("scan_idle_end",   32'(busy), 32'd0);

    // Pass-through: stop at 2, continue to 4, no gaps
    req_pulse(5'b10100);
    chk("pass_dir_up", 32'(dir_up), 32'd1);
    run(16);
    chk("pass_stop2_floor", 32'(floor), 32'd2);
    chk("pass_stop2_clr",   32'(clr), 32'b00100);
    chk("pass_no_gap",      32'(c_up), 32'd16);
    chk("pass_no_stop1",    32'(c_clr), 32'd1);
    run(6);
    chk("pass_idle2", 32'(busy), 32'd0);
    run(1);
    chk("pass_resume", 32'(mot_up), 32'd1);
    run(16);
    chk("pass_stop4_floor", 32'(floor), 32'd4);
    chk("pass_stop4_clr",   32'(clr), 32'b10000);
    chk("pass_door_cycles", 32'(c_door), 32'd7);
    run(6);
    chk("pass_clr_pulses", 32'(c_clr), 32'd2);
    chk("clr_onehot",      32'(c_multi), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
